// File: rtl/bs_pkg.sv
// Shared constants and state type for the Black-Scholes call/put pricer.
// Optional direct-put datapath is selected by the macro BS_PUT_DIRECT_EN.
package bs_pkg;

   localparam int FRAC = 16;
   localparam logic signed [31:0] ONE_Q = 32'sh0001_0000;
   localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL1 = 3'd1,
      S_MUL2 = 3'd2,
      S_MUL3 = 3'd3,
      S_MUL4 = 3'd4,
      S_COMB = 3'd5
   } state_t;

endpackage

// File: rtl/q_mul_sat.sv
// Combinational signed fixed-point multiply with round-half-up and saturation.
module q_mul_sat #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic signed [WIDTH-1:0] o_p
);

   localparam logic signed [2*WIDTH-1:0] RND = (2*WIDTH)'(1) << (FRAC-1);
   localparam logic signed [2*WIDTH-1:0] HI  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] LO  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] w_prod;
   logic signed [2*WIDTH-1:0] w_shf;

   assign w_prod = i_a * i_b;
   assign w_shf  = (w_prod + RND) >>> FRAC;

   // clamp the rescaled product into the representable range
   always_comb begin
      if (w_shf > HI) begin
         o_p = HI[WIDTH-1:0];
      end else if (w_shf < LO) begin
         o_p = LO[WIDTH-1:0];
      end else begin
         o_p = w_shf[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/bs_price.sv
// Black-Scholes call/put pricer: one shared multiplier sequenced by a small FSM.
// Define BS_PUT_DIRECT_EN to compute the put directly (two extra multiply states).
module bs_price #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] nd1,
   input  logic signed [WIDTH-1:0] nd2,
   input  logic signed [WIDTH-1:0] spot,
   input  logic signed [WIDTH-1:0] kdisc,
   output logic signed [WIDTH-1:0] call,
   output logic signed [WIDTH-1:0] put,
   output logic                    busy,
   output logic                    done
);
   import bs_pkg::*;

   localparam logic [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   state_t r_state, w_next;
   logic signed [WIDTH-1:0] r_nd1, r_nd2, r_spot, r_kdisc, r_t1, r_t2;
   logic signed [WIDTH-1:0] r_call, r_put;
   logic                    r_done;
   logic signed [WIDTH-1:0] w_ma, w_mb, w_prod, w_call, w_put;
   logic signed [WIDTH:0]   w_c;

   q_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
      .i_a (w_ma),
      .i_b (w_mb),
      .o_p (w_prod)
   );

`ifdef BS_PUT_DIRECT_EN
   localparam logic signed [WIDTH-1:0] W_ONE = WIDTH'(1) << FRAC;
   logic signed [WIDTH-1:0] r_t3, r_t4;
   logic signed [WIDTH:0]   w_pd;
`else
   logic signed [WIDTH+1:0] w_p;
`endif

   // multiplier operand select by state
   always_comb begin
      w_ma = '0;
      w_mb = '0;
      case (r_state)
         S_MUL1: begin w_ma = r_spot;  w_mb = r_nd1; end
         S_MUL2: begin w_ma = r_kdisc; w_mb = r_nd2; end
`ifdef BS_PUT_DIRECT_EN
         S_MUL3: begin w_ma = r_kdisc; w_mb = W_ONE - r_nd2; end
         S_MUL4: begin w_ma = r_spot;  w_mb = W_ONE - r_nd1; end
`endif
         default: begin w_ma = '0; w_mb = '0; end
      endcase
   end

   // next-state sequencing
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start) w_next = S_MUL1; else w_next = S_IDLE;
         S_MUL1: w_next = S_MUL2;
`ifdef BS_PUT_DIRECT_EN
         S_MUL2: w_next = S_MUL3;
         S_MUL3: w_next = S_MUL4;
         S_MUL4: w_next = S_COMB;
`else
         S_MUL2: w_next = S_COMB;
`endif
         S_COMB: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // call = t1 - t2 widened by one bit, clamped to [0, max]
   always_comb begin
      w_c = {r_t1[WIDTH-1], r_t1} - {r_t2[WIDTH-1], r_t2};
      if (w_c[WIDTH]) begin
         w_call = '0;
      end else if (w_c[WIDTH-1]) begin
         w_call = W_MAX;
      end else begin
         w_call = w_c[WIDTH-1:0];
      end
   end

`ifdef BS_PUT_DIRECT_EN
   // direct put from the two complementary products, clamped to [0, max]
   always_comb begin
      w_pd = {r_t3[WIDTH-1], r_t3} - {r_t4[WIDTH-1], r_t4};
      if (w_pd[WIDTH]) begin
         w_put = '0;
      end else if (w_pd[WIDTH-1]) begin
         w_put = W_MAX;
      end else begin
         w_put = w_pd[WIDTH-1:0];
      end
   end
`else
   // put-call parity on the clamped call, two guard bits
   always_comb begin
      w_p = {2'b00, w_call} - {{2{r_spot[WIDTH-1]}}, r_spot}
            + {{2{r_kdisc[WIDTH-1]}}, r_kdisc};
      if (w_p[WIDTH+1]) begin
         w_put = '0;
      end else if (|w_p[WIDTH:WIDTH-1]) begin
         w_put = W_MAX;
      end else begin
         w_put = w_p[WIDTH-1:0];
      end
   end
`endif

   // state, operand latches, partial products and registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_nd1   <= '0;
         r_nd2   <= '0;
         r_spot  <= '0;
         r_kdisc <= '0;
         r_t1    <= '0;
         r_t2    <= '0;
         r_call  <= '0;
         r_put   <= '0;
         r_done  <= 1'b0;
`ifdef BS_PUT_DIRECT_EN
         r_t3    <= '0;
         r_t4    <= '0;
`endif
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_nd1   <= nd1;
                  r_nd2   <= nd2;
                  r_spot  <= spot;
                  r_kdisc <= kdisc;
               end
            end
            S_MUL1: r_t1 <= w_prod;
            S_MUL2: r_t2 <= w_prod;
`ifdef BS_PUT_DIRECT_EN
            S_MUL3: r_t3 <= w_prod;
            S_MUL4: r_t4 <= w_prod;
`endif
            S_COMB: begin
               r_call <= w_call;
               r_put  <= w_put;
               r_done <= 1'b1;
            end
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign call = r_call;
   assign put  = r_put;
   assign done = r_done;
   assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_bs_price.sv
// Self-checking bench for bs_price: directed corner cases plus random operands
// checked against an arithmetic reference model of the pricing formulas.
module tb_bs_price;
   import bs_pkg::*;

`ifdef BS_PUT_DIRECT_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 4;
`endif

   logic clk = 1'b0;
   logic reset, start, busy, done;
   logic signed [31:0] nd1, nd2, spot, kdisc, call, put;
   int n_assert = 0;
   int n_fail = 0;
   int last_c = 0;
   int last_p = 0;

   bs_price #(.WIDTH(32), .FRAC(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .nd1(nd1), .nd2(nd2), .spot(spot), .kdisc(kdisc),
      .call(call), .put(put), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic longint sat_q(input longint v);
      if (v > longint'(Q_MAX)) return longint'(Q_MAX);
      if (v < longint'(Q_MIN)) return longint'(Q_MIN);
      return v;
   endfunction

   function automatic int clamp0(input longint v);
      if (v < 0) return 0;
      return int'(sat_q(v));
   endfunction

   // real-valued product a*b/2^16, rounded half up, then saturated
   function automatic int qmul(input int a, input int b);
      longint p;
      p = longint'(a) * longint'(b);
      p = (p + 64'sd32768) >>> 16;
      return int'(sat_q(p));
   endfunction

   function automatic int model_call(input int s, input int k, input int n1, input int n2);
      return clamp0(longint'(qmul(s, n1)) - longint'(qmul(k, n2)));
   endfunction

   function automatic int model_put(input int s, input int k, input int n1, input int n2);
      int one;
      one = int'(ONE_Q);
`ifdef BS_PUT_DIRECT_EN
      return clamp0(longint'(qmul(k, one - n2)) - longint'(qmul(s, one - n1)));
`else
      return clamp0(longint'(model_call(s, k, n1, n2)) - longint'(s) + longint'(k));
`endif
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // issue one start; walk the pipeline checking busy/done each cycle and results in the done cycle
   task automatic do_op(input int s, input int k, input int n1, input int n2, input bit glitch);
      int ec, ep;
      ec = model_call(s, k, n1, n2);
      ep = model_put(s, k, n1, n2);
      spot = s; kdisc = k; nd1 = n1; nd2 = n2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         if (glitch && (i == 1 || i == 2)) begin
            start = 1'b1;
            spot = $urandom; kdisc = $urandom; nd1 = $urandom; nd2 = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         chk1("done", done, (i == LAT-1));
         chk1("busy", busy, (i < LAT-1));
      end
      start = 1'b0;
      chk32("call", call, ec);
      chk32("put", put, ep);
      last_c = ec;
      last_p = ep;
   endtask

   // one idle cycle: done must drop and results must hold
   task automatic idle_chk();
      @(posedge clk); #1;
      chk1("done_idle", done, 1'b0);
      chk32("call_hold", call, last_c);
      chk32("put_hold", put, last_p);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      nd1 = '0; nd2 = '0; spot = '0; kdisc = '0;
      repeat (3) @(posedge clk);
      #1;
      chk32("rst_call", call, 32'h0000_0000);
      chk32("rst_put", put, 32'h0000_0000);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op(32'h0064_0000, 32'h005F_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
      chk32("t1_call_const", call, 32'h0005_0000);
      idle_chk();
      do_op(32'h0050_0000, 32'h005F_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
`ifndef BS_PUT_DIRECT_EN
      chk32("t2_put_const", put, 32'h000F_0000);
`endif
      idle_chk();
      do_op(32'h0000_8000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
      chk32("round_call", call, 32'h0000_0001);
      idle_chk();
      do_op(32'h7FFF_0000, 32'h0000_0000, 32'h0002_0000, 32'h0000_0000, 1'b0);
      chk32("sat_call", call, 32'h7FFF_FFFF);
      idle_chk();

      // extra starts while busy are ignored; a start in the done cycle is accepted
      do_op(32'h0064_0000, 32'h005A_0000, 32'h0000_C000, 32'h0000_8000, 1'b1);
      do_op(32'h0032_0000, 32'h0028_0000, 32'h0000_4000, 32'h0000_E000, 1'b0);
      idle_chk();

      // reset while in MUL2 aborts the calculation
      spot = 32'h0064_0000; kdisc = 32'h005F_0000; nd1 = 32'h0001_0000; nd2 = 32'h0000_8000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk32("abort_call", call, 32'h0000_0000);
      chk32("abort_put", put, 32'h0000_0000);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      last_c = 0; last_p = 0;
      for (int i = 0; i < LAT; i++) idle_chk();
      do_op(32'h0064_0000, 32'h005F_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
      idle_chk();

      // random operands: realistic ranges mixed with unconstrained words
      for (int n = 0; n < 40; n++) begin
         int s, k, a, b;
         if (n % 4 == 3) begin
            s = $urandom; k = $urandom; a = $urandom; b = $urandom;
         end else begin
            s = int'($urandom_range(32'h00C8_0000, 0));
            k = int'($urandom_range(32'h00C8_0000, 0));
            a = int'($urandom_range(32'h0001_0000, 0));
            b = int'($urandom_range(32'h0001_0000, 0));
         end
         do_op(s, k, a, b, ($urandom_range(3, 0) == 0));
         if ($urandom_range(1, 0) == 1) idle_chk();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bs_price.md
Name: bs_price

Overview:
- Consumer at the far end of the normal-CDF stage in the Black-Scholes datapath.
- Takes N(d1) and N(d2) with their completion pulse, plus spot S and discounted strike Kd = K·e^(-rT).
- Produces the European call price C = S·N(d1) − Kd·N(d2) and the put price P.
- Uses a single shared Q16.16 multiplier sequenced by a small FSM.

Parameters:
- WIDTH, 32, data width of all signed fixed-point operands and results.
- FRAC, 16, fractional bits (Q16.16).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; operands valid this cycle (driven by CDF stage done)
- nd1  input  WIDTH  signed Q16.16 N(d1)
- nd2  input  WIDTH  signed Q16.16 N(d2)
- spot  input  WIDTH  signed Q16.16 S
- kdisc  input  WIDTH  signed Q16.16 Kd
- call  output  WIDTH  signed Q16.16 call price, registered
- put  output  WIDTH  signed Q16.16 put price, registered
- busy  output  1  high while state ≠ IDLE
- done  output  1  one-cycle pulse when call/put update

Behaviour:
- Reset (synchronous): state=IDLE; call=0, put=0, done=0, busy=0; internal terms cleared. Reset mid-operation aborts the calculation: no done pulse, outputs forced to 0.
- States: IDLE → MUL1 → MUL2 → COMB → IDLE.
- IDLE:
  - On start=1, latch nd1, nd2, spot and kdisc, then go to MUL1.
  - start in any other state is ignored; the operands are not re-latched.
- MUL1: t1 = qmul(spot, nd1).
- MUL2: t2 = qmul(kdisc, nd2).
- COMB:
  - c = sat(t1 − t2), computed at WIDTH+1 bits.
  - p = sat(c − spot + kdisc), computed at WIDTH+2 bits.
  - Negative c or p is clamped to 0.
  - Register call and put, set done=1, go to IDLE.
- qmul:
  - Full 2·WIDTH signed product.
  - Add 1<<(FRAC−1) (round half up toward +inf).
  - Arithmetic shift right by FRAC.
  - Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Latency: start sampled at edge k → done high in cycle k+4 (exactly one cycle). call/put change only at that edge and hold otherwise.
- done cycle: state is already IDLE, so a start coinciding with done is accepted (throughput: one result per 4 cycles).
- Inputs outside [0,1] for nd1/nd2 are not checked; saturation alone bounds the results.

Optional Feature:
- Macro: BS_PUT_DIRECT_EN.
- Defined:
  - Put is computed directly as sat(qmul(kdisc, ONE−nd2) − qmul(spot, ONE−nd1)), clamped at 0.
  - Adds states MUL3 and MUL4 between MUL2 and COMB; latency becomes 6 cycles.
  - call is unchanged.
- Undefined: put uses put-call parity as specified above; latency is 4.

Decomposition:
- Shared package bs_pkg:
  - FRAC
  - ONE_Q (1.0 in Q16.16, 0x0001_0000)
  - Q_MAX, Q_MIN saturation constants
  - state enum type
- Sub-module q_mul_sat: combinational Q16.16 multiply with round-half-up and saturation. It is instantiated once and its operands are muxed by state.

Test Plan:
- spot=0x00640000 (100), kdisc=0x005F0000 (95), nd1=nd2=0x00010000 → call=0x00050000 (5.0), put=0, done exactly at start+4.
- spot=0x00500000 (80), kdisc=0x005F0000 (95), nd1=nd2=0 → call=0, put=0x000F0000 (15.0).
- Rounding: spot=0x00008000, nd1=0x00000001, kdisc=0, nd2=0 → call=0x00000001, put=0 (clamped).
- Saturation: spot=0x7FFF0000, nd1=0x00020000, kdisc=0, nd2=0 → call=0x7FFFFFFF, no wrap.
- Extra start pulses at start+1 and start+2 → ignored; single done at start+4 with the first operand set. A start in the done cycle → second done at +4 later.
- reset asserted while in MUL2 → no done, call=put=busy=0. A subsequent start produces the correct result after 4 cycles.
